// File: rtl/fixed_point_coprocessor.sv
// Signed Q-format coprocessor: ADD/SUB (2 cycles), radix-2 shift-add MUL, restoring SQRT.
// Optional build macro FPU_SATURATE_EN clamps ADD/SUB/MUL overflow instead of wrapping.
module fixed_point_coprocessor #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             overflow
);

  localparam int RW = WIDTH + FBITS;
  localparam int NS = RW / 2;
  localparam logic [6:0] MUL_LAST  = 7'(WIDTH);
  localparam logic [6:0] SQRT_LAST = 7'(NS);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    SQRT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, mcand;
  logic             neg_q;
  logic [2*WIDTH-1:0] prod;
  logic [RW-1:0]    rad;
  logic [NS+1:0]    rem;
  logic [NS-1:0]    root;
  logic [6:0]       cnt;

  logic             accept, finish;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   add_sum, psum;
  logic [WIDTH-1:0] mul_mag, mul_val;
  logic             mul_above, mul_at, mul_low, mul_ovf;
  logic [NS+3:0]    minu, subt;
  logic [NS+1:0]    diff;
  logic [WIDTH-1:0] res_calc, final_res;
  logic             ovf_calc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    ready      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          case (operation)
            2'b00, 2'b01: state_next = ADDSUB;
            2'b10:        state_next = MUL;
            default:      state_next = SQRT;
          endcase
        end
      end
      ADDSUB: begin
        busy       = 1'b1;
        finish     = 1'b1;
        state_next = DONE;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == MUL_LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      SQRT: begin
        busy = 1'b1;
        if (cnt == SQRT_LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_abs   = operand_1[WIDTH-1] ? -operand_1 : operand_1;
  assign b_abs   = operand_2[WIDTH-1] ? -operand_2 : operand_2;
  assign add_sum = op_q[0] ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                           : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});
  assign psum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

  // Overflow of floor(product / 2^FBITS) judged on the magnitude: a negative
  // result may reach exactly -2^(WIDTH-1) only when no fraction bits are lost.
  assign mul_above = |prod[2*WIDTH-1:WIDTH+FBITS];
  assign mul_at    = prod[WIDTH+FBITS-1];
  assign mul_low   = |prod[WIDTH+FBITS-2:0];
  assign mul_ovf   = neg_q ? (mul_above | (mul_at & mul_low)) : (mul_above | mul_at);
  assign mul_mag   = prod[WIDTH+FBITS-1:FBITS];
  assign mul_val   = neg_q ? -mul_mag : mul_mag;

  assign minu = {rem, rad[RW-1 -: 2]};
  assign subt = {2'b00, root, 2'b01};
  assign diff = minu[NS+1:0] - subt[NS+1:0];

  always_comb begin
    res_calc = '0;
    ovf_calc = 1'b0;
    case (op_q)
      2'b00, 2'b01: begin
        res_calc = add_sum[WIDTH-1:0];
        ovf_calc = add_sum[WIDTH] ^ add_sum[WIDTH-1];
      end
      2'b10: begin
        res_calc = mul_val;
        ovf_calc = mul_ovf;
      end
      default: begin
        res_calc = a_q[WIDTH-1] ? '0 : WIDTH'(root);
        ovf_calc = a_q[WIDTH-1];
      end
    endcase
  end

`ifdef FPU_SATURATE_EN
  logic sat_neg;
  assign sat_neg   = (op_q == 2'b10) ? neg_q : add_sum[WIDTH];
  assign final_res = (ovf_calc && op_q != 2'b11) ? (sat_neg ? MIN_NEG : MAX_POS) : res_calc;
`else
  assign final_res = res_calc;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      prod     <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= operation;
        a_q   <= operand_1;
        b_q   <= operand_2;
        neg_q <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
        mcand <= b_abs;
        prod  <= {{WIDTH{1'b0}}, a_abs};
        rad   <= {operand_1, {FBITS{1'b0}}};
        rem   <= '0;
        root  <= '0;
        cnt   <= '0;
      end else if (state == MUL && !finish) begin
        prod <= {psum, prod[WIDTH-1:1]};
        cnt  <= cnt + 1'b1;
      end else if (state == SQRT && !finish) begin
        if (minu >= subt) begin
          rem  <= diff;
          root <= {root[NS-2:0], 1'b1};
        end else begin
          rem  <= minu[NS+1:0];
          root <= {root[NS-2:0], 1'b0};
        end
        rad <= rad << 2;
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        result   <= final_res;
        overflow <= ovf_calc;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_coprocessor.sv
// Self-checking bench for fixed_point_coprocessor (WIDTH=32, FBITS=10) against an arithmetic reference model.
module tb_fixed_point_coprocessor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  operation;
  logic [31:0] operand_1, operand_2;
  logic [31:0] result;
  logic        ready, busy, overflow;

  int errors = 0;
  int checks = 0;

  fixed_point_coprocessor #(.WIDTH(32), .FBITS(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .operation (operation),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .result    (result),
    .ready     (ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the Q-format values.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output int lat);
    longint sa, sb, v, mag, fl, x, rt;
    logic [63:0] vb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 1'b0; lat = 2;
    case (op)
      2'b00, 2'b01: begin
        v  = (op == 2'b00) ? sa + sb : sa - sb;
        o  = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        vb = v;
        r  = vb[31:0];
`ifdef FPU_SATURATE_EN
        if (o) r = (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        lat = 2;
      end
      2'b10: begin
        v   = sa * sb;
        mag = (v < 0) ? -v : v;
        mag = mag >> 10;
        fl  = v >>> 10;
        o   = (fl > 64'sd2147483647) || (fl < -64'sd2147483648);
        vb  = (v < 0) ? -mag : mag;
        r   = vb[31:0];
`ifdef FPU_SATURATE_EN
        if (o) r = (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        lat = 34;
      end
      default: begin
        lat = 23;
        if (sa < 0) begin
          r = '0;
          o = 1'b1;
        end else begin
          x  = sa <<< 10;
          rt = longint'($sqrt(real'(x)));
          while (rt * rt > x) rt--;
          while ((rt + 1) * (rt + 1) <= x) rt++;
          vb = rt;
          r  = vb[31:0];
          o  = 1'b0;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h1, 32'hFFFF_FFFF};
    case ($urandom_range(0, 2))
      0:       return 32'($urandom);
      1:       return 32'($urandom_range(0, 65535)) - 32'd32768;
      default: return edges[$urandom_range(0, 4)];
    endcase
  endfunction

  // One transaction; with spam set, start stays high with fresh random inputs every cycle.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit spam, input string tag);
    logic [31:0] er, prev;
    logic        eo;
    int          el, cyc, busy_cnt;
    bit          hold_ok;
    model(op, a, b, er, eo, el);
    prev = result;
    @(negedge clk);
    start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
    cyc = 0; busy_cnt = 0; hold_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!spam) start = 1'b0;
      else begin
        operation = 2'($urandom);
        operand_1 = $urandom;
        operand_2 = $urandom;
      end
      if (busy) busy_cnt++;
      if (!ready && result !== prev) hold_ok = 1'b0;
    end while (!ready && cyc < 100);
    chk({tag, "_latency"}, 64'(cyc), 64'(el));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_overflow"}, 64'(overflow), 64'(eo));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(el));
    chk({tag, "_result_held"}, 64'(hold_ok), 64'(1));
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ready_single"}, 64'(ready), 64'(0));
    chk({tag, "_idle_after"}, 64'(busy), 64'(0));
    chk({tag, "_result_stable"}, 64'(result), 64'(er));
  endtask

  initial begin
    int          rcount;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset_n = 1'b0; start = 1'b0; operation = '0; operand_1 = '0; operand_2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 64'(busy), 64'(0));

    run(2'b00, 32'h0000_0600, 32'h0000_0900, 1'b0, "add_dir");
    chk("add_dir_const", 64'(result), 64'h0F00);
    run(2'b10, 32'h0000_0600, 32'hFFFF_F700, 1'b0, "mul_dir");
    chk("mul_dir_const", 64'(result), 64'hFFFF_F280);
    run(2'b11, 32'h0000_1000, 32'h0, 1'b0, "sqrt_dir");
    chk("sqrt_dir_const", 64'(result), 64'h0800);
    run(2'b11, 32'hFFFF_FC00, 32'h0, 1'b0, "sqrt_neg");
    run(2'b00, 32'h7FFF_FFFF, 32'h0000_0400, 1'b0, "add_ovf");
    run(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, "sub_ovf");
    run(2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, "mul_ovf");
    run(2'b11, 32'h7FFF_FFFF, 32'h0, 1'b0, "sqrt_max");

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; operation = 2'b10; operand_1 = 32'h0000_0600; operand_2 = 32'hFFFF_F700;
    @(negedge clk);
    start = 1'b0;
    rcount = 0;
    repeat (9) begin
      @(negedge clk);
      if (ready) rcount++;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_no_ready", 64'(rcount), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ready", 64'(ready), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run(2'b01, 32'h0000_0800, 32'h0000_0400, 1'b0, "sub_after_reset");

    run(2'b11, 32'h0000_1000, 32'h0, 1'b1, "sqrt_spam");

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      if (op == 2'b11 && $urandom_range(0, 3) != 0) a[31] = 1'b0;
      run(op, a, b, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_coprocessor.md
FIXED_POINT_COPROCESSOR -- requirements
Module: fixed_point_coprocessor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; legal range 8..64.
REQ-002 SHALL have parameter FBITS, default 10: fractional bits, signed two's-complement Q format; 0 < FBITS < WIDTH, and WIDTH+FBITS even.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port operation  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 SQRT.
REQ-007 SHALL have ports operand_1, operand_2  input  WIDTH  signed Q operands; SQRT uses operand_1 only.
REQ-008 SHALL have port result  output  WIDTH  Q-format result register.
REQ-009 SHALL have port ready  output  1  one-cycle completion pulse; result valid from this cycle on.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start through the ready cycle.
REQ-011 SHALL have port overflow  output  1  status of the last completed operation, valid with ready.

Function
REQ-012 SHALL implement FSM states IDLE, ADDSUB, MUL, SQRT, DONE; DONE asserts ready and returns to IDLE next cycle.
REQ-013 SHALL capture operation and operands in internal registers on the accepted start cycle; later input changes have no effect on the operation in flight.
REQ-014 SHALL ignore start while busy; a start in the DONE cycle is ignored.
REQ-015 ADD/SUB SHALL compute in WIDTH+1 bits and complete with ready 2 cycles after start.
REQ-016 MUL SHALL use a radix-2 shift-add datapath on magnitudes (one bit per cycle, WIDTH iterations), restore sign, and take bits [WIDTH+FBITS-1:FBITS] of the 2*WIDTH product, truncating toward zero; ready WIDTH+2 cycles after start.
REQ-017 MUL overflow SHALL be set when the signed 2*WIDTH product, shifted right by FBITS, is not representable in WIDTH bits.
REQ-018 SQRT SHALL be a restoring digit-by-digit root of operand_1 zero-extended by FBITS, using (WIDTH+FBITS)/2 iterations, one per cycle, with the result in Q format; ready (WIDTH+FBITS)/2+2 cycles after start.
REQ-019 SQRT of a negative operand_1 SHALL return 0 with overflow=1 and the same latency.
REQ-020 result and overflow SHALL hold their values until the next ready pulse.
REQ-021 An undefined state encoding SHALL return to IDLE with no ready pulse.

Reset
REQ-022 reset_n low SHALL asynchronously force state IDLE, result=0, ready=0, busy=0, overflow=0, and clear all datapath registers.
REQ-023 reset_n asserted mid-operation SHALL abort the operation with no ready pulse; the first start after release is accepted normally.
REQ-024 Deassertion of reset_n SHALL take effect on the next rising clk edge; the block SHALL be idle after it.

Configuration
REQ-025 With macro FPU_SATURATE_EN defined, ADD/SUB/MUL overflow SHALL clamp result to the maximum positive or minimum negative value by the sign of the true result, and set overflow=1.
REQ-026 Without FPU_SATURATE_EN, ADD/SUB/MUL results SHALL wrap modulo 2^WIDTH with overflow still reported; SQRT behaviour is identical in both builds.

Verification (WIDTH=32, FBITS=10)
REQ-027 ADD 0x00000600 + 0x00000900 (1.5+2.25) -> ready exactly 2 cycles after start, result 0x00000F00, overflow=0.
REQ-028 MUL 0x00000600 * 0xFFFFF700 (1.5*-2.25) -> ready 34 cycles after start, result 0xFFFFF280 (-3.375), overflow=0, busy high for 34 cycles.
REQ-029 SQRT 0x00001000 (4.0) -> ready 23 cycles after start, result 0x00000800; SQRT 0xFFFFFC00 -> result 0, overflow=1.
REQ-030 ADD 0x7FFFFFFF + 0x00000400 -> with FPU_SATURATE_EN result 0x7FFFFFFF, overflow=1; without, result 0x800003FF, overflow=1.
REQ-031 Start MUL, pulse reset_n low at cycle 10, release, start SUB 0x800 - 0x400 -> no ready for MUL, SUB ready 2 cycles after start with result 0x400.
REQ-032 Assert start with changing operands every cycle during a SQRT -> extra starts ignored, single ready pulse, result from originally captured operand.
